// File: rtl/seg_scan_reader.sv
// seg_scan_reader
//
// Passive readback of the multiplexed 7-segment display bus. It synchronises
// the scanned segment and common lines and waits for each digit slot to hold
// steady. It then decodes the lit pattern back to a hex code and gathers one
// code per slot. When all six slots have been seen, the set is published as
// one frame.
//
// Ports:
//   clk_i           system clock (single domain)
//   rst_ni          asynchronous active-low reset
//   a_i..g_i        segment lines, active-high (1 = lit)
//   com3_i..com8_i  digit commons, active-low (one low = that digit selected)
//   dig3_o..dig8_o  published code per slot: 00-0F hex, 10 blank, 1F unknown
//   frame_valid_o   one-cycle pulse when a frame is published
//   frame_changed_o one-cycle pulse with frame_valid_o if any digit changed
//   err_o           one-cycle pulse on entry into a multiple-common condition
//   stale_o         level, no frame published for TIMEOUT cycles
module seg_scan_reader #(
  parameter int unsigned STABLE  = 4,
  parameter logic [19:0] TIMEOUT = 20'd1000000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_i,
  input  logic       d_i,
  input  logic       e_i,
  input  logic       f_i,
  input  logic       g_i,
  input  logic       com3_i,
  input  logic       com4_i,
  input  logic       com5_i,
  input  logic       com6_i,
  input  logic       com7_i,
  input  logic       com8_i,
  output logic [4:0] dig3_o,
  output logic [4:0] dig4_o,
  output logic [4:0] dig5_o,
  output logic [4:0] dig6_o,
  output logic [4:0] dig7_o,
  output logic [4:0] dig8_o,
  output logic       frame_valid_o,
  output logic       frame_changed_o,
  output logic       err_o,
  output logic       stale_o
);

  localparam logic [3:0] CntMax = 4'(STABLE);
  localparam logic [3:0] CntArm = 4'(STABLE - 1);
  localparam logic [4:0] Blank  = 5'h10;

  // Bit i of the common vector corresponds to com(i+3).
  logic [6:0] segRaw;
  logic [5:0] comRaw;

  assign segRaw = {a_i, b_i, c_i, d_i, e_i, f_i, g_i};
  assign comRaw = {com8_i, com7_i, com6_i, com5_i, com4_i, com3_i};

  logic [6:0]      segMeta_q, segSync_q, prevSeg_q;
  logic [5:0]      comMeta_q, comSync_q, prevCom_q;
  logic [3:0]      stableCnt_q, stableCnt_d;
  logic            armed_q, armed_d;
  logic [5:0]      seen_q, seen_d;
  logic [5:0][4:0] shadow_q, shadow_d;
  logic [5:0][4:0] digs_q, digs_d;
  logic            frameValid_q, frameValid_d;
  logic            frameChanged_q, frameChanged_d;
  logic            multiPrev_q;
  logic            err_q, err_d;
  logic [19:0]     toCnt_q, toCnt_d;
  logic            stale_q, stale_d;

  logic [5:0] comActive;
  logic       oneHot;
  logic       multi;
  logic       qualified;
  logic       capture;
  logic       publish;
  logic [2:0] slotIdx;
  logic [4:0] code;

  function automatic logic [4:0] decodeGlyph(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'b1111110: res = 5'h00;
      7'b0110000: res = 5'h01;
      7'b1101101: res = 5'h02;
      7'b1111001: res = 5'h03;
      7'b0110011: res = 5'h04;
      7'b1011011: res = 5'h05;
      7'b1011111: res = 5'h06;
      7'b1110000: res = 5'h07;
      7'b1111111: res = 5'h08;
      7'b1111011: res = 5'h09;
      7'b1110111: res = 5'h0A;
      7'b0011111: res = 5'h0B;
      7'b1001110: res = 5'h0C;
      7'b0111101: res = 5'h0D;
      7'b1001111: res = 5'h0E;
      7'b1000111: res = 5'h0F;
      7'b0000000: res = Blank;
      default:    res = 5'h1F;
    endcase
    return res;
  endfunction

  // Slot qualification, capture and frame assembly.
  always_comb begin
    comActive = ~comSync_q;
    oneHot    = (comActive != 6'd0) && ((comActive & (comActive - 6'd1)) == 6'd0);
    multi     = (comActive != 6'd0) && !oneHot;

    slotIdx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (comActive[i]) slotIdx = 3'(i);
    end

    qualified = oneHot && (comSync_q == prevCom_q) && (segSync_q == prevSeg_q);
    // The arm is cleared by a capture and set again only by an unqualified
    // cycle. This limits each stable dwell to a single capture.
    capture   = qualified && armed_q && (stableCnt_q == CntArm);
    code      = decodeGlyph(segSync_q);
    publish   = (seen_q == 6'h3F);

    stableCnt_d = 4'd0;
    armed_d     = 1'b1;
    if (qualified) begin
      stableCnt_d = (stableCnt_q == CntMax) ? stableCnt_q : stableCnt_q + 4'd1;
      armed_d     = capture ? 1'b0 : armed_q;
    end

    // A capture in the publish cycle is the first slot of the next frame.
    seen_d   = publish ? 6'd0 : seen_q;
    shadow_d = shadow_q;
    if (capture) begin
      seen_d[slotIdx]   = 1'b1;
      shadow_d[slotIdx] = code;
    end

    digs_d         = publish ? shadow_q : digs_q;
    frameValid_d   = publish;
    frameChanged_d = publish && (shadow_q != digs_q);

    err_d = multi && !multiPrev_q;

    toCnt_d = 20'd0;
    stale_d = 1'b0;
    if (!publish) begin
      toCnt_d = (toCnt_q == TIMEOUT) ? toCnt_q : toCnt_q + 20'd1;
      stale_d = stale_q || (toCnt_d == TIMEOUT);
    end
  end

  // Input synchroniser, previous-sample history and all state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      segMeta_q      <= '0;
      segSync_q      <= '0;
      comMeta_q      <= '1;
      comSync_q      <= '1;
      prevSeg_q      <= '0;
      prevCom_q      <= '1;
      stableCnt_q    <= '0;
      armed_q        <= 1'b1;
      seen_q         <= '0;
      shadow_q       <= {6{Blank}};
      digs_q         <= {6{Blank}};
      frameValid_q   <= 1'b0;
      frameChanged_q <= 1'b0;
      multiPrev_q    <= 1'b0;
      err_q          <= 1'b0;
      toCnt_q        <= '0;
      stale_q        <= 1'b0;
    end else begin
      segMeta_q      <= segRaw;
      segSync_q      <= segMeta_q;
      comMeta_q      <= comRaw;
      comSync_q      <= comMeta_q;
      prevSeg_q      <= segSync_q;
      prevCom_q      <= comSync_q;
      stableCnt_q    <= stableCnt_d;
      armed_q        <= armed_d;
      seen_q         <= seen_d;
      shadow_q       <= shadow_d;
      digs_q         <= digs_d;
      frameValid_q   <= frameValid_d;
      frameChanged_q <= frameChanged_d;
      multiPrev_q    <= multi;
      err_q          <= err_d;
      toCnt_q        <= toCnt_d;
      stale_q        <= stale_d;
    end
  end

  assign dig3_o          = digs_q[0];
  assign dig4_o          = digs_q[1];
  assign dig5_o          = digs_q[2];
  assign dig6_o          = digs_q[3];
  assign dig7_o          = digs_q[4];
  assign dig8_o          = digs_q[5];
  assign frame_valid_o   = frameValid_q;
  assign frame_changed_o = frameChanged_q;
  assign err_o           = err_q;
  assign stale_o         = stale_q;

endmodule

// File: tb/tb_seg_scan_reader.sv
// tb_seg_scan_reader
//
// Bench for seg_scan_reader with STABLE=4 and TIMEOUT=100. Every output is
// compared against a behavioural model on each falling edge. Directed scans
// cover the decode table, short dwells, double commons, stale and reset. A
// randomized scan phase then runs against the same model.
module tb_seg_scan_reader;

  localparam int STABLE     = 4;
  localparam int TimeoutCyc = 100;
  localparam logic [12:0] IdleBus = {6'h3F, 7'h00};
  localparam logic [6:0] GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  typedef struct {
    logic [6:0] seg;
    logic [4:0] code;
  } glyphVec_t;

  logic       clk_i  = 1'b0;
  logic       rst_ni = 1'b0;
  logic [5:0] comDrv = 6'h3F;
  logic [6:0] segDrv = 7'h00;

  logic [4:0] dig3_o, dig4_o, dig5_o, dig6_o, dig7_o, dig8_o;
  logic       frame_valid_o, frame_changed_o, err_o, stale_o;

  int checkCount = 0;
  int passCount  = 0;
  int fvCount    = 0;
  int fcCount    = 0;
  int errCount   = 0;

  glyphVec_t vecTable [18];

  seg_scan_reader #(
    .STABLE (STABLE),
    .TIMEOUT(20'(TimeoutCyc))
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .a_i            (segDrv[6]),
    .b_i            (segDrv[5]),
    .c_i            (segDrv[4]),
    .d_i            (segDrv[3]),
    .e_i            (segDrv[2]),
    .f_i            (segDrv[1]),
    .g_i            (segDrv[0]),
    .com3_i         (comDrv[0]),
    .com4_i         (comDrv[1]),
    .com5_i         (comDrv[2]),
    .com6_i         (comDrv[3]),
    .com7_i         (comDrv[4]),
    .com8_i         (comDrv[5]),
    .dig3_o         (dig3_o),
    .dig4_o         (dig4_o),
    .dig5_o         (dig5_o),
    .dig6_o         (dig6_o),
    .dig7_o         (dig7_o),
    .dig8_o         (dig8_o),
    .frame_valid_o  (frame_valid_o),
    .frame_changed_o(frame_changed_o),
    .err_o          (err_o),
    .stale_o        (stale_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- reference model ----------------
  logic [12:0]     pipeQ [$];
  logic [12:0]     vPrev;
  int              runLen;
  logic [5:0]      mSeen;
  logic [5:0][4:0] mShadow;
  logic [5:0][4:0] mDig;
  logic            mFv, mFc, mErr, mStale;
  int              mStaleCnt;

  function automatic int countLow(input logic [5:0] c);
    int n = 0;
    for (int i = 0; i < 6; i++) if (!c[i]) n++;
    return n;
  endfunction

  function automatic int firstLow(input logic [5:0] c);
    for (int i = 0; i < 6; i++) if (!c[i]) return i;
    return 0;
  endfunction

  function automatic logic [4:0] refDecode(input logic [6:0] s);
    if (s == 7'h00) return 5'h10;
    for (int i = 0; i < 16; i++) if (GLYPH[i] == s) return 5'(i);
    return 5'h1F;
  endfunction

  task automatic modelReset();
    pipeQ     = '{IdleBus, IdleBus};
    vPrev     = IdleBus;
    runLen    = 0;
    mSeen     = '0;
    mShadow   = {6{5'h10}};
    mDig      = {6{5'h10}};
    mFv       = 1'b0;
    mFc       = 1'b0;
    mErr      = 1'b0;
    mStale    = 1'b0;
    mStaleCnt = 0;
  endtask

  // One clock edge: the value seen by the reader is the bus from two edges ago.
  task automatic modelStep();
    logic [12:0] v;
    int          lows;
    int          slot;
    bit          cap;
    bit          pub;
    v    = pipeQ[0];
    lows = countLow(v[12:7]);
    slot = firstLow(v[12:7]);
    if (lows == 1 && v == vPrev) runLen++;
    else runLen = (lows == 1) ? 1 : 0;
    cap = (lows == 1) && (runLen == STABLE + 1);
    pub = (mSeen == 6'h3F);
    mFv = pub;
    mFc = pub && (mShadow != mDig);
    if (pub) begin
      mDig      = mShadow;
      mSeen     = '0;
      mStaleCnt = 0;
      mStale    = 1'b0;
    end else begin
      if (mStaleCnt < TimeoutCyc) mStaleCnt++;
      if (mStaleCnt == TimeoutCyc) mStale = 1'b1;
    end
    if (cap) begin
      mShadow[slot] = refDecode(v[6:0]);
      mSeen[slot]   = 1'b1;
    end
    mErr  = (lows >= 2) && (countLow(vPrev[12:7]) < 2);
    vPrev = v;
    void'(pipeQ.pop_front());
    pipeQ.push_back({comDrv, segDrv});
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) modelReset();
      else modelStep();
    end
  end

  // ---------------- checking ----------------
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      checkOutput("model digits", 32'({dig8_o, dig7_o, dig6_o, dig5_o, dig4_o, dig3_o}), 32'(mDig));
      checkOutput("model frame_valid", 32'(frame_valid_o), 32'(mFv));
      checkOutput("model frame_changed", 32'(frame_changed_o), 32'(mFc));
      checkOutput("model err", 32'(err_o), 32'(mErr));
      checkOutput("model stale", 32'(stale_o), 32'(mStale));
      if (frame_valid_o === 1'b1) fvCount++;
      if (frame_changed_o === 1'b1) fcCount++;
      if (err_o === 1'b1) errCount++;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [4:0] digAt(input int i);
    logic [29:0] all;
    all = {dig8_o, dig7_o, dig6_o, dig5_o, dig4_o, dig3_o};
    return all[i*5 +: 5];
  endfunction

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input logic [5:0] c, input logic [6:0] s, input int n);
    @(negedge clk_i);
    comDrv = c;
    segDrv = s;
    repeat (n - 1) @(negedge clk_i);
  endtask

  task automatic scanFrame(input logic [5:0][6:0] pats, input int dwell);
    for (int i = 0; i < 6; i++) applyStimulus(~(6'b1 << i), pats[i], dwell);
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    comDrv = 6'h3F;
    segDrv = 7'h00;
    repeat (cycles) @(negedge clk_i);
    #2;
    rst_ni = 1'b1;
  endtask

  logic [5:0][6:0] pats;
  int              fvBase, fcBase, errBase, ptr, r, dwell;
  logic [5:0]      c;
  logic [6:0]      s;

  initial begin
    for (int i = 0; i < 16; i++) begin
      vecTable[i].seg  = GLYPH[i];
      vecTable[i].code = 5'(i);
    end
    // Last frame of the table puts blank on com4 and an unknown glyph on com7.
    vecTable[12] = '{7'b1001110, 5'h0C};
    vecTable[13] = '{7'b0000000, 5'h10};
    vecTable[14] = '{7'b0111101, 5'h0D};
    vecTable[15] = '{7'b1001111, 5'h0E};
    vecTable[16] = '{7'b1010101, 5'h1F};
    vecTable[17] = '{7'b1000111, 5'h0F};

    // Reset values, then stale after exactly TIMEOUT idle cycles.
    repeat (3) @(negedge clk_i);
    checkOutput("reset digits", 32'({dig8_o, dig7_o, dig6_o, dig5_o, dig4_o, dig3_o}), 32'({6{5'h10}}));
    checkOutput("reset strobes", 32'({frame_valid_o, frame_changed_o, err_o, stale_o}), 32'd0);
    #2;
    rst_ni = 1'b1;
    repeat (99) @(posedge clk_i);
    #1;
    checkOutput("stale before timeout", 32'(stale_o), 32'd0);
    @(posedge clk_i);
    #1;
    checkOutput("stale at timeout", 32'(stale_o), 32'd1);

    // Clean scan 1..6, then the identical scan again.
    for (int i = 0; i < 6; i++) pats[i] = GLYPH[i + 1];
    fvBase = fvCount;
    fcBase = fcCount;
    scanFrame(pats, 20);
    checkOutput("clean digits", 32'({dig8_o, dig7_o, dig6_o, dig5_o, dig4_o, dig3_o}),
                32'({5'h6, 5'h5, 5'h4, 5'h3, 5'h2, 5'h1}));
    checkOutput("clean fv count", 32'(fvCount - fvBase), 32'd1);
    checkOutput("clean fc count", 32'(fcCount - fcBase), 32'd1);
    checkOutput("stale cleared", 32'(stale_o), 32'd0);
    fvBase = fvCount;
    fcBase = fcCount;
    scanFrame(pats, 20);
    checkOutput("repeat fv count", 32'(fvCount - fvBase), 32'd1);
    checkOutput("repeat fc count", 32'(fcCount - fcBase), 32'd0);

    // Decode table, six glyphs per frame.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 6; i++) pats[i] = vecTable[6 * f + i].seg;
      scanFrame(pats, 20);
      for (int i = 0; i < 6; i++) checkOutput("decode", 32'(digAt(i)), 32'(vecTable[6 * f + i].code));
    end

    // Short com5 dwell is ignored; a later long dwell completes the frame.
    fvBase = fvCount;
    applyStimulus(~6'b000001, GLYPH[1], 20);
    applyStimulus(~6'b000010, GLYPH[2], 20);
    applyStimulus(~6'b000100, GLYPH[3], 4);
    applyStimulus(~6'b001000, GLYPH[4], 20);
    applyStimulus(~6'b010000, GLYPH[5], 20);
    applyStimulus(~6'b100000, GLYPH[6], 20);
    checkOutput("short dwell no publish", 32'(fvCount - fvBase), 32'd0);
    applyStimulus(~6'b000100, GLYPH[9], 8);
    applyStimulus(6'h3F, 7'h00, 5);
    checkOutput("long dwell publish", 32'(fvCount - fvBase), 32'd1);
    checkOutput("long dwell dig5", 32'(dig5_o), 32'h9);

    // Double common: one err pulse, no capture, seen kept.
    fvBase  = fvCount;
    errBase = errCount;
    applyStimulus(~6'b000001, GLYPH[7], 20);
    applyStimulus(~6'b000010, GLYPH[8], 20);
    applyStimulus(~6'b000100, GLYPH[9], 20);
    applyStimulus(6'b110110, GLYPH[8], 10);
    applyStimulus(6'h3F, 7'h00, 4);
    checkOutput("double common err count", 32'(errCount - errBase), 32'd1);
    checkOutput("double common no publish", 32'(fvCount - fvBase), 32'd0);
    applyStimulus(~6'b001000, GLYPH[10], 20);
    applyStimulus(~6'b010000, GLYPH[11], 20);
    applyStimulus(~6'b100000, GLYPH[12], 20);
    checkOutput("resume publish", 32'(fvCount - fvBase), 32'd1);
    checkOutput("resume dig3", 32'(dig3_o), 32'h7);
    checkOutput("resume dig6", 32'(dig6_o), 32'hA);

    // Reset after three captured slots discards the partial frame.
    applyStimulus(~6'b000001, GLYPH[14], 20);
    applyStimulus(~6'b000010, GLYPH[15], 20);
    applyStimulus(~6'b000100, GLYPH[0], 20);
    doReset(3);
    checkOutput("midreset digits", 32'({dig8_o, dig7_o, dig6_o, dig5_o, dig4_o, dig3_o}), 32'({6{5'h10}}));
    checkOutput("midreset strobes", 32'({frame_valid_o, frame_changed_o, err_o, stale_o}), 32'd0);
    fvBase = fvCount;
    applyStimulus(~6'b001000, GLYPH[3], 20);
    applyStimulus(~6'b010000, GLYPH[4], 20);
    applyStimulus(~6'b100000, GLYPH[5], 20);
    checkOutput("partial after reset", 32'(fvCount - fvBase), 32'd0);
    for (int i = 0; i < 6; i++) pats[i] = GLYPH[15 - i];
    scanFrame(pats, 20);
    checkOutput("full after reset", 32'(fvCount - fvBase), 32'd1);

    // Randomized scanning, checked every cycle against the model.
    ptr = 0;
    for (int k = 0; k < 300; k++) begin
      r     = int'($urandom_range(0, 99));
      s     = ($urandom_range(0, 3) != 0) ? vecTable[$urandom_range(0, 17)].seg : 7'($urandom);
      dwell = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(5, 14));
      if (r < 70) begin
        c   = ~(6'b1 << ptr);
        ptr = (ptr + 1) % 6;
      end else if (r < 80) begin
        c = ~(6'b1 << $urandom_range(0, 5));
      end else if (r < 88) begin
        c = 6'h3F;
      end else if (r < 97) begin
        c = 6'($urandom) & ~(6'b000011 << $urandom_range(0, 4));
      end else begin
        doReset(int'($urandom_range(1, 3)));
        c = 6'h3F;
      end
      applyStimulus(c, s, dwell);
    end
    applyStimulus(6'h3F, 7'h00, 10);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
